seq_signed_divider: RTL



---
 rtl/div_pkg.sv | 24 ++
 rtl/div_restore_step.sv | 28 ++
 rtl/seq_signed_divider.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand widths, saturation constants and the iteration counter width.
package div_pkg;

  localparam int DW_N_DEF = 16;
  localparam int DW_D_DEF = 8;

  // The iteration counter counts down from DW_N-1 to 0, so it needs $clog2(DW_N) bits.
  localparam int CNT_W = $clog2(DW_N_DEF);

  // Saturated quotients returned for divide-by-zero and MIN/-1 overflow.
  // These follow the default dividend width; a different DW_N needs matching values here.
  localparam logic [DW_N_DEF-1:0] Q_MAX = {1'b0, {(DW_N_DEF-1){1'b1}}};
  localparam logic [DW_N_DEF-1:0] Q_MIN = {1'b1, {(DW_N_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor magnitude,
// and keep the difference only when it does not go negative.
module div_restore_step #(
  parameter int DW_D = 8
) (
  input  logic [DW_D-1:0] rem_in,
  input  logic            bit_in,
  input  logic [DW_D-1:0] dmag,
  output logic [DW_D-1:0] rem_out,
  output logic            q_bit
);

  logic [DW_D:0]   shifted;
  logic [DW_D-1:0] diff;

  // The incoming remainder is always below dmag, so the shifted value is below
  // 2*dmag and a single subtraction decides the bit. When it succeeds the true
  // difference is below dmag and therefore fits in DW_D bits, which is why the
  // subtraction only needs the low DW_D bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted[DW_D-1:0] - dmag;
    q_bit   = (shifted >= {1'b0, dmag});
    rem_out = q_bit ? diff : shifted[DW_D-1:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (restoring, one quotient bit per cycle) with a
// valid/ready handshake on both sides. Quotient truncates toward zero and the
// remainder carries the sign of the dividend. Latency from accept to out_valid
// is DW_N+2 cycles for every operand pair, including the saturating special cases.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int DW_N = DW_N_DEF,
  parameter int DW_D = DW_D_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic        [DW_N-1:0] dividend,
  input  logic        [DW_D-1:0] divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW_N-1:0] quotient,
  output logic signed [DW_D-1:0] remainder,
  output logic                   ovf,
  output logic                   dbz,
  output logic                   busy
);

  state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic [DW_N-1:0]  dvd_r;
  logic [DW_D-1:0]  dvs_r;
  logic [DW_N-1:0]  quo_r;
  logic [DW_D-1:0]  rem_r;
  logic [DW_D-1:0]  dmag_r;
  logic             neg_n;
  logic             neg_d;
  logic             dbz_r;
  logic             ovf_r;

  logic [DW_D-1:0]  step_rem;
  logic             step_q;

  // The magnitudes are read as unsigned values, so the same-width two's
  // complement negation of the most negative operand yields its true magnitude
  // (e.g. 0x8000 reads as 32768) without spending an extra register bit.
  logic [DW_N-1:0]  abs_n;
  logic [DW_D-1:0]  abs_d;

  // Operand magnitudes for the PREP cycle.
  always_comb begin
    abs_n = dvd_r[DW_N-1] ? -dvd_r : dvd_r;
    abs_d = dvs_r[DW_D-1] ? -dvs_r : dvs_r;
  end

  div_restore_step #(
    .DW_D (DW_D)
  ) u_step (
    .rem_in  (rem_r),
    .bit_in  (quo_r[DW_N-1]),
    .dmag    (dmag_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register; a low rst_n abandons any division in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs; only IDLE accepts operands and only DONE presents a result.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = PREP;
      end
      PREP: next_state = ITER;
      ITER: if (count == '0) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture operands, form magnitudes and flags, iterate the
  // restoring steps, then apply signs and saturation into the result registers.
  // The result registers only change in FIX, so they stay put through DONE and
  // keep their values after the handshake until the next result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      dmag_r    <= '0;
      neg_n     <= 1'b0;
      neg_d     <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
          end
        end
        PREP: begin
          quo_r  <= abs_n;
          dmag_r <= abs_d;
          rem_r  <= '0;
          neg_n  <= dvd_r[DW_N-1];
          neg_d  <= dvs_r[DW_D-1];
          dbz_r  <= (dvs_r == '0);
          ovf_r  <= (dvd_r == {1'b1, {(DW_N-1){1'b0}}}) && (dvs_r == '1);
          count  <= CNT_W'(DW_N-1);
        end
        ITER: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[DW_N-2:0], step_q};
          count <= count - CNT_W'(1);
        end
        FIX: begin
          if (dbz_r) begin
            quotient  <= neg_n ? Q_MIN : Q_MAX;
            remainder <= '0;
            dbz       <= 1'b1;
            ovf       <= 1'b0;
          end else if (ovf_r) begin
            quotient  <= Q_MAX;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= (neg_n ^ neg_d) ? -quo_r : quo_r;
            remainder <= neg_n ? -rem_r : rem_r;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
